// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a PC through instruction memory, issuing
// registered fetches with stall, redirect and halt-opcode handling.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [3:0] HALT_OPCODE = 4'b1010
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [7:0]  i_redirect_addr,
  output logic [7:0]  o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_instr_out,
  output logic        o_instr_valid,
  output logic [7:0]  o_pc_out,
  output logic        o_halted,
  output logic        o_busy,
  output logic [15:0] o_issue_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_pc_out;
  logic        r_valid;
  logic [15:0] r_count;
  logic        r_halted;
  logic        r_busy;

  state_t      w_state_nx;
  logic [7:0]  w_pc_nx;
  logic [31:0] w_instr_nx;
  logic [7:0]  w_pc_out_nx;
  logic        w_valid_nx;
  logic [15:0] w_count_nx;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_halted <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_instr  <= w_instr_nx;
      r_pc_out <= w_pc_out_nx;
      r_valid  <= w_valid_nx;
      r_count  <= w_count_nx;
      r_halted <= (w_state_nx == ST_HALT);
      r_busy   <= (w_state_nx == ST_RUN);
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_instr_nx  = r_instr;
    w_pc_out_nx = r_pc_out;
    w_valid_nx  = 1'b0;
    w_count_nx  = r_count;
    case (r_state)
      ST_IDLE: begin
        w_pc_nx = RESET_PC;
        if (i_start) begin
          w_state_nx = ST_RUN;
          w_count_nx = '0;
        end
      end
      ST_RUN: begin
        // Priority: redirect, then stall, then normal issue (with halt detect).
        if (i_redirect) begin
          w_pc_nx    = i_redirect_addr;
          w_instr_nx = '0;
        end else if (!i_stall) begin
          w_instr_nx  = i_imem_instr;
          w_pc_out_nx = r_pc;
          w_valid_nx  = 1'b1;
          if (r_count != '1) begin
            w_count_nx = r_count + 16'd1;
          end
          if (i_imem_instr[31:28] == HALT_OPCODE) begin
            w_state_nx = ST_HALT;
          end else begin
            w_pc_nx = r_pc + 8'd1;
          end
        end
      end
      ST_HALT: begin
        if (i_start) begin
          w_state_nx = ST_RUN;
          w_pc_nx    = RESET_PC;
          w_count_nx = '0;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign o_imem_addr   = r_pc;
  assign o_instr_out   = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc_out      = r_pc_out;
  assign o_issue_count = r_count;
  assign o_halted      = r_halted;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each driven cycle pushes its expected
// outputs, which are popped and compared one time unit after the clock edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;
  logic        busy;
  logic [15:0] issue_count;

  logic [31:0] mem [256];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    string       tag;
    logic [7:0]  addr;
    logic [31:0] instr;
    logic        valid;
    logic [7:0]  pc;
    logic        halted;
    logic        busy;
    logic [15:0] count;
  } exp_t;

  exp_t sb[$];

  fetch_sequencer #(.RESET_PC(8'h00), .HALT_OPCODE(4'b1010)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_imem_addr     (imem_addr),
    .i_imem_instr    (imem_instr),
    .o_instr_out     (instr_out),
    .o_instr_valid   (instr_valid),
    .o_pc_out        (pc_out),
    .o_halted        (halted),
    .o_busy          (busy),
    .o_issue_count   (issue_count)
  );

  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] addr, input logic [31:0] instr,
                          input logic valid, input logic [7:0] pc, input logic h,
                          input logic b, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.addr = addr; e.instr = instr; e.valid = valid;
    e.pc = pc; e.halted = h; e.busy = b; e.count = cnt;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_val({e.tag, ".addr"},   {24'd0, imem_addr},   {24'd0, e.addr});
    check_val({e.tag, ".instr"},  instr_out,            e.instr);
    check_val({e.tag, ".valid"},  {31'd0, instr_valid}, {31'd0, e.valid});
    check_val({e.tag, ".pc_out"}, {24'd0, pc_out},      {24'd0, e.pc});
    check_val({e.tag, ".halted"}, {31'd0, halted},      {31'd0, e.halted});
    check_val({e.tag, ".busy"},   {31'd0, busy},        {31'd0, e.busy});
    check_val({e.tag, ".count"},  {16'd0, issue_count}, {16'd0, e.count});
  endtask

  // Drive one cycle of inputs, then compare after the edge.
  task automatic step(input logic s, input logic st, input logic rd, input logic [7:0] ra);
    start = s; stall = st; redirect = rd; redirect_addr = ra;
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 + i;

    #12;
    push_exp("reset", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    compare_front();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    push_exp("idle_hold", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp("start", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 5; k++) begin
      push_exp("seq", 8'(k + 1), 32'h0100_0000 + k, 1'b1, 8'(k), 1'b0, 1'b1, 16'(k + 1));
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end

    push_exp("redir", 8'h32, 32'h0, 1'b0, 8'h04, 1'b0, 1'b1, 16'd5);
    step(1'b0, 1'b0, 1'b1, 8'h32);
    push_exp("after_redir", 8'h33, 32'h0100_0032, 1'b1, 8'h32, 1'b0, 1'b1, 16'd6);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    push_exp("stall_redir", 8'h64, 32'h0, 1'b0, 8'h32, 1'b0, 1'b1, 16'd6);
    step(1'b0, 1'b1, 1'b1, 8'h64);
    for (int k = 0; k < 3; k++) begin
      push_exp("stall", 8'h64, 32'h0, 1'b0, 8'h32, 1'b0, 1'b1, 16'd6);
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    push_exp("after_stall", 8'h65, 32'h0100_0064, 1'b1, 8'h64, 1'b0, 1'b1, 16'd7);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    push_exp("redir_same", 8'h65, 32'h0, 1'b0, 8'h64, 1'b0, 1'b1, 16'd7);
    step(1'b0, 1'b0, 1'b1, 8'h65);

    mem[8'h69] = 32'hA040_0000;
    push_exp("redir_halt", 8'h69, 32'h0, 1'b0, 8'h64, 1'b0, 1'b1, 16'd7);
    step(1'b0, 1'b0, 1'b1, 8'h69);
    push_exp("halt_issue", 8'h69, 32'hA040_0000, 1'b1, 8'h69, 1'b1, 1'b0, 16'd8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp("halt_ignore", 8'h69, 32'hA040_0000, 1'b0, 8'h69, 1'b1, 1'b0, 16'd8);
    step(1'b0, 1'b1, 1'b1, 8'h10);
    push_exp("halt_restart", 8'h00, 32'hA040_0000, 1'b0, 8'h69, 1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    push_exp("start_in_run", 8'h01, 32'h0100_0000, 1'b1, 8'h00, 1'b0, 1'b1, 16'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    mem[8'h00] = 32'h0;
    push_exp("redir_ff", 8'hFF, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    push_exp("fetch_ff", 8'h00, 32'h0100_00FF, 1'b1, 8'hFF, 1'b0, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp("wrap_zero_instr", 8'h01, 32'h0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd3);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    #3;
    rst = 1'b1;
    #1;
    push_exp("async_reset", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    compare_front();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    push_exp("post_reset_idle", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    mem[8'h00] = 32'h0100_0000;
    mem[8'h69] = 32'h0100_0069;
    push_exp("sat_start", 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    start = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    push_exp("saturate", 8'h05, 32'h0100_0004, 1'b1, 8'h04, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp("saturate_hold", 8'h06, 32'h0100_0005, 1'b1, 8'h05, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC loaded on reset and on every start.
REQ-002 Parameter HALT_OPCODE, default 4'b1010: instr[31:28] value that ends a run.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; begins fetching from RESET_PC when in IDLE or HALT.
REQ-006 stall  input  1  hold PC and fetch outputs this cycle.
REQ-007 redirect  input  1  load PC from redirect_addr this cycle.
REQ-008 redirect_addr  input  8  new fetch address.
REQ-009 imem_addr  output  8  address to instruction memory; equals the PC register.
REQ-010 imem_instr  input  32  instruction-memory data for imem_addr, valid before the next posedge.
REQ-011 instr_out  output  32  registered fetched instruction.
REQ-012 instr_valid  output  1  instr_out is a real fetch issued this cycle.
REQ-013 pc_out  output  8  address that instr_out was fetched from.
REQ-014 halted  output  1  high while in HALT.
REQ-015 busy  output  1  high while in RUN.
REQ-016 issue_count  output  16  number of valid fetches since the last start; saturates at 16'hFFFF.

Function
REQ-017 FSM states: IDLE, RUN, HALT; all outputs registered; busy = (state==RUN), halted = (state==HALT).
REQ-018 IDLE: pc = RESET_PC, instr_valid = 0; when start = 1, go to RUN with pc <= RESET_PC and issue_count <= 0.
REQ-019 RUN, normal cycle (no redirect, no stall): capture imem_instr into instr_out and pc into pc_out, set instr_valid <= 1, set pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00), and increment issue_count.
REQ-020 RUN with stall = 1 and redirect = 0: pc, instr_out, pc_out and issue_count hold; instr_valid <= 0.
REQ-021 RUN with redirect = 1: pc <= redirect_addr, instr_out <= 32'h0, instr_valid <= 0 (one-cycle bubble), issue_count holds.
REQ-022 Redirect takes priority over stall, and both take priority over halt detection.
REQ-023 Redirect to the current pc is legal and still inserts the bubble.
REQ-024 RUN normal cycle with imem_instr[31:28] == HALT_OPCODE: the instruction is issued normally per REQ-019 except that pc holds, and the FSM goes to HALT.
REQ-025 HALT: pc, instr_out, pc_out and issue_count hold; instr_valid <= 0; stall and redirect are ignored.
REQ-026 HALT with start = 1: the FSM goes to RUN with pc <= RESET_PC and issue_count <= 0.
REQ-027 start is ignored in RUN.
REQ-028 An all-zero instruction is an ordinary instruction: it is issued and counted.
REQ-029 issue_count stays at 16'hFFFF once reached.
REQ-030 Implementation target: 120-400 lines of RTL, no memories inferred.

Reset
REQ-031 Reset is asynchronous and active-high, and forces: state = IDLE, pc = RESET_PC, instr_out = 32'h0, pc_out = 8'h00, instr_valid = 0, issue_count = 0, halted = 0, busy = 0.
REQ-032 Reset asserted mid-RUN or mid-HALT aborts immediately to the REQ-031 values, with no partial issue on the following edge.
REQ-033 After reset deassertion, the FSM stays in IDLE until start = 1 is sampled on a posedge.

Verification
REQ-034 Sequential fetch: memory word[n] = 32'h0100_0000+n; pulse start; run 4 cycles -> pc_out = 0,1,2,3 on successive cycles, instr_valid = 1 on each, issue_count = 4.
REQ-035 Redirect: in RUN at pc = 5, redirect = 1 with redirect_addr = 8'h32 -> next cycle instr_valid = 0 and instr_out = 0, imem_addr = 8'h32; following cycle pc_out = 8'h32 with instr_valid = 1.
REQ-036 Stall plus redirect in the same cycle: redirect_addr = 8'h64 -> redirect wins, imem_addr = 8'h64; stall alone for 3 cycles -> imem_addr and issue_count unchanged, instr_valid = 0.
REQ-037 Halt: word[8'h69] = 32'hA040_0000, redirect to 8'h69 -> that word issues with instr_valid = 1, then halted = 1, busy = 0, instr_valid = 0; start = 1 -> RUN from pc 0 with issue_count reset.
REQ-038 Wrap and saturation: redirect to 8'hFF -> the next fetch is at 8'h00; forcing the count path past 65535 fetches -> issue_count = 16'hFFFF.
REQ-039 Asynchronous reset between clock edges during RUN -> all outputs take the REQ-031 values before the next posedge.
